// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace buffer: CPU state encoding, tracker states, record layout.
// COMMIT_TRACE_CYCLES_EN adds the 4-bit cycle-count field to each FIFO entry.
package commit_trace_pkg;

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;

    typedef enum logic {
        T_IDLE   = 1'b0,
        T_ACTIVE = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        wen;
        logic [3:0]  cycles;
    } commit_rec_t;

    localparam int REC_BASE_W = 32 + 6 + 5 + 32 + 1;
`ifdef COMMIT_TRACE_CYCLES_EN
    localparam int REC_W = REC_BASE_W + 4;
`else
    localparam int REC_W = REC_BASE_W;
`endif

    // FIFO entry layout, MSB first: pc, op, wreg, wdata, wen[, cycles]
    function automatic commit_rec_t rec_unpack(input logic [REC_W-1:0] v);
        commit_rec_t r;
        r       = '0;
        r.pc    = v[REC_W-1  -: 32];
        r.op    = v[REC_W-33 -: 6];
        r.wreg  = v[REC_W-39 -: 5];
        r.wdata = v[REC_W-44 -: 32];
        r.wen   = v[REC_W-76];
`ifdef COMMIT_TRACE_CYCLES_EN
        r.cycles = v[3:0];
`endif
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Generic DEPTH-entry synchronous FIFO, head word visible on o_dout.
// A push while full is accepted only when a pop happens in the same cycle.
module commit_trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Builds one commit record per retired MultiCycleCPU instruction and queues it for a trace sink.
// Define COMMIT_TRACE_CYCLES_EN to record the per-instruction cycle count in trace_cycles.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       state,
    input  logic [31:0]      curPC,
    input  logic [5:0]       Op,
    input  logic             RegWre,
    input  logic [4:0]       WriteReg,
    input  logic [31:0]      WriteData,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [5:0]       trace_op,
    output logic [4:0]       trace_wreg,
    output logic [31:0]      trace_wdata,
    output logic             trace_wen,
    output logic [3:0]       trace_cycles,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [31:0]      retired_count
);

    localparam int AW = $clog2(DEPTH);

    trk_state_t        r_trk, w_trk_next;
    logic [2:0]        r_prev_state;
    logic [31:0]       r_pc, w_pc_next;
    logic [5:0]        r_op, w_op_next;
    logic [4:0]        r_wreg, w_wreg_next;
    logic [31:0]       r_wdata, w_wdata_next;
    logic              r_wen, w_wen_next;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop;
    logic [31:0]       r_retired;

    logic              w_retire, w_commit, w_pop, w_push, w_drop;
    logic              w_full, w_empty;
    logic [AW:0]       w_count;
    logic [REC_W-1:0]  w_din, w_dout;
    commit_rec_t       w_head;

    assign w_retire = (r_prev_state != S_IF) && (state == S_IF);
    assign w_commit = w_retire && (r_trk == T_ACTIVE);
    assign w_pop    = !w_empty && trace_ready;
    assign w_push   = w_commit && (!w_full || w_pop);
    assign w_drop   = w_commit && w_full && !w_pop;

    always_comb begin
        w_trk_next   = r_trk;
        w_pc_next    = r_pc;
        w_op_next    = r_op;
        w_wreg_next  = r_wreg;
        w_wdata_next = r_wdata;
        w_wen_next   = r_wen;
        case (r_trk)
            T_IDLE: begin
                if (state != S_IF) begin
                    w_trk_next   = T_ACTIVE;
                    w_pc_next    = curPC;
                    w_op_next    = Op;
                    w_wreg_next  = RegWre ? WriteReg  : 5'd0;
                    w_wdata_next = RegWre ? WriteData : 32'd0;
                    w_wen_next   = RegWre;
                end
            end
            T_ACTIVE: begin
                if (w_retire) begin
                    w_trk_next = T_IDLE;
                end else if (RegWre) begin
                    w_wreg_next  = WriteReg;
                    w_wdata_next = WriteData;
                    w_wen_next   = 1'b1;
                end
            end
            default: w_trk_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_trk        <= T_IDLE;
            r_prev_state <= S_IF;
            r_pc         <= '0;
            r_op         <= '0;
            r_wreg       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop       <= '0;
            r_retired    <= '0;
        end else begin
            r_trk        <= w_trk_next;
            r_prev_state <= state;
            r_pc         <= w_pc_next;
            r_op         <= w_op_next;
            r_wreg       <= w_wreg_next;
            r_wdata      <= w_wdata_next;
            r_wen        <= w_wen_next;
            if (w_commit) r_retired <= r_retired + 32'd1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop != {CNT_W{1'b1}}) r_drop <= r_drop + 1'b1;
            end
        end
    end

`ifdef COMMIT_TRACE_CYCLES_EN
    logic [3:0] r_cycles, w_cycles_next;

    // The leave-IF cycle counts as 1; the retiring IF cycle is not counted
    always_comb begin
        w_cycles_next = r_cycles;
        if (r_trk == T_IDLE) begin
            if (state != S_IF) w_cycles_next = 4'd1;
        end else if (!w_retire && r_cycles != 4'hF) begin
            w_cycles_next = r_cycles + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_cycles <= '0;
        else      r_cycles <= w_cycles_next;
    end

    assign w_din = {r_pc, r_op, r_wreg, r_wdata, r_wen, r_cycles};
`else
    assign w_din = {r_pc, r_op, r_wreg, r_wdata, r_wen};
`endif

    commit_trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head        = rec_unpack(w_dout);
    assign trace_valid   = !w_empty;
    assign trace_pc      = w_head.pc;
    assign trace_op      = w_head.op;
    assign trace_wreg    = w_head.wreg;
    assign trace_wdata   = w_head.wdata;
    assign trace_wen     = w_head.wen;
    assign trace_cycles  = w_head.cycles;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed-vector bench for commit_trace_buffer; expected cycle counts follow COMMIT_TRACE_CYCLES_EN.
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

`ifdef COMMIT_TRACE_CYCLES_EN
    localparam logic [3:0] EXP_C3 = 4'd3;
    localparam logic [3:0] EXP_CF = 4'hF;
`else
    localparam logic [3:0] EXP_C3 = 4'd0;
    localparam logic [3:0] EXP_CF = 4'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  state;
    logic [31:0] curPC;
    logic [5:0]  Op;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [5:0]  trace_op;
    logic [4:0]  trace_wreg;
    logic [31:0] trace_wdata;
    logic        trace_wen;
    logic [3:0]  trace_cycles;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [31:0] retired_count;

    int n_total = 0;
    int n_bad   = 0;

    commit_trace_buffer #(.DEPTH(8), .CNT_W(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .state         (state),
        .curPC         (curPC),
        .Op            (Op),
        .RegWre        (RegWre),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_op      (trace_op),
        .trace_wreg    (trace_wreg),
        .trace_wdata   (trace_wdata),
        .trace_wen     (trace_wen),
        .trace_cycles  (trace_cycles),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .retired_count (retired_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] st, input logic rw, input logic [4:0] wr, input logic [31:0] wd);
        state     = st;
        RegWre    = rw;
        WriteReg  = wr;
        WriteData = wd;
        @(posedge CLK);
        #1;
    endtask

    // One IF cycle, n non-IF cycles (ID, EXE..., WB/MEM), then the retiring IF cycle
    task automatic instr(input logic [31:0] pc, input logic [5:0] op, input int n, input bit store,
                         input bit wr, input logic [4:0] wreg, input logic [31:0] wdata,
                         input bit pop_at_retire);
        logic [2:0] st;
        curPC = pc;
        Op    = op;
        cyc(S_IF, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i == 0)          st = S_ID;
            else if (i == n - 1) st = store ? S_MEM : S_WB;
            else                 st = S_EXE;
            cyc(st, wr && (i == n - 1), wreg, wdata);
        end
        if (pop_at_retire) trace_ready = 1'b1;
        cyc(S_IF, 1'b0, 5'd0, 32'd0);
        if (pop_at_retire) trace_ready = 1'b0;
        $display("txn retire pc=%08h valid=%0d head_pc=%08h retired=%0d drops=%0d",
                 pc, trace_valid, trace_pc, retired_count, drop_count);
    endtask

    initial begin
        RST = 1'b0; state = S_IF; curPC = '0; Op = '0;
        RegWre = 1'b0; WriteReg = '0; WriteData = '0; trace_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_pc", trace_pc, 32'd0);
        RST = 1'b1;

        // single instruction with register write
        trace_ready = 1'b1;
        instr(32'h4, 6'h00, 3, 1'b0, 1'b1, 5'd3, 32'h7, 1'b0);
        chk("i1_valid", 32'(trace_valid), 32'd1);
        chk("i1_pc", trace_pc, 32'h4);
        chk("i1_op", 32'(trace_op), 32'h0);
        chk("i1_wreg", 32'(trace_wreg), 32'd3);
        chk("i1_wdata", trace_wdata, 32'h7);
        chk("i1_wen", 32'(trace_wen), 32'd1);
        chk("i1_cycles", 32'(trace_cycles), 32'(EXP_C3));
        chk("i1_retired", retired_count, 32'd1);

        // store, no register write
        instr(32'h8, 6'h2b, 3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("st_valid", 32'(trace_valid), 32'd1);
        chk("st_pc", trace_pc, 32'h8);
        chk("st_op", 32'(trace_op), 32'h2b);
        chk("st_wen", 32'(trace_wen), 32'd0);
        chk("st_cycles", 32'(trace_cycles), 32'(EXP_C3));
        chk("st_retired", retired_count, 32'd2);
        cyc(S_IF, 1'b0, 5'd0, 32'd0);
        chk("st_popped", 32'(trace_valid), 32'd0);

        // back-pressure: 10 retirements into an 8-deep FIFO
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            instr(32'h100 + 32'(4 * i), 6'(i), 3, 1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
            if (i == 7) begin
                chk("full_no_ovf", 32'(overflow), 32'd0);
                chk("full_no_drop", 32'(drop_count), 32'd0);
            end
        end
        chk("ovf_valid", 32'(trace_valid), 32'd1);
        chk("ovf_head", trace_pc, 32'h100);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_retired", retired_count, 32'd12);

        // full FIFO: retire coincides with a pop
        instr(32'h200, 6'h11, 3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("pp_drop", 32'(drop_count), 32'd2);
        chk("pp_retired", retired_count, 32'd13);
        chk("pp_head", trace_pc, 32'h104);

        // drain: 7 remaining originals then the record pushed during the pop
        trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", 32'(trace_valid), 32'd1);
            chk("drain_pc", trace_pc, (k < 7) ? 32'h104 + 32'(4 * k) : 32'h200);
            $display("txn drain idx=%0d pc=%08h", k, trace_pc);
            cyc(S_IF, 1'b0, 5'd0, 32'd0);
        end
        chk("drain_empty", 32'(trace_valid), 32'd0);
        chk("drain_sticky", 32'(overflow), 32'd1);

        // asynchronous reset in the middle of EXE
        trace_ready = 1'b0;
        curPC = 32'h300;
        Op    = 6'h08;
        cyc(S_IF, 1'b0, 5'd0, 32'd0);
        cyc(S_ID, 1'b0, 5'd0, 32'd0);
        state = S_EXE;
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("mr_valid", 32'(trace_valid), 32'd0);
        chk("mr_overflow", 32'(overflow), 32'd0);
        chk("mr_drop", 32'(drop_count), 32'd0);
        chk("mr_retired", retired_count, 32'd0);
        chk("mr_pc", trace_pc, 32'd0);
        chk("mr_wdata", trace_wdata, 32'd0);
        state = S_IF;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (3) cyc(S_IF, 1'b0, 5'd0, 32'd0);
        chk("mr_no_rec", 32'(trace_valid), 32'd0);
        chk("mr_no_ret", retired_count, 32'd0);
        $display("txn reset valid=%0d retired=%0d", trace_valid, retired_count);

        // cycle-count saturation: 20 cycles outside IF
        trace_ready = 1'b1;
        instr(32'h400, 6'h23, 20, 1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0);
        chk("sat_valid", 32'(trace_valid), 32'd1);
        chk("sat_pc", trace_pc, 32'h400);
        chk("sat_cycles", 32'(trace_cycles), 32'(EXP_CF));
        chk("sat_wreg", 32'(trace_wreg), 32'd31);
        chk("sat_wdata", trace_wdata, 32'hDEADBEEF);
        chk("sat_retired", retired_count, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the MultiCycleCPU, on its debug outputs.
- Watches the CPU's 3-bit `state` and register-write signals, detects each instruction retirement, and builds a commit record: PC, opcode, destination register, write data, write-enable flag and cycle count.
- Buffers records in a small FIFO and drains them over a valid/ready port to the simulation monitor or an on-chip trace sink.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- CNT_W, 8: width of the drop counter (saturating).

Ports:
- CLK, input, 1: clock; everything is rising-edge.
- RST, input, 1: asynchronous, active-low reset.
- state, input, 3: CPU control state; encoding comes from the package.
- curPC, input, 32: CPU current PC.
- Op, input, 6: current opcode.
- RegWre, input, 1: register-file write strobe.
- WriteReg, input, 5: register-file write address.
- WriteData, input, 32: register-file write data.
- trace_valid, output, 1: the head record is valid.
- trace_ready, input, 1: the sink accepts the head record.
- trace_pc, output, 32: head record PC.
- trace_op, output, 6: head record opcode.
- trace_wreg, output, 5: head record destination register.
- trace_wdata, output, 32: head record write data.
- trace_wen, output, 1: the head instruction wrote a register.
- trace_cycles, output, 4: head instruction cycle count.
- overflow, output, 1: sticky flag, set when a record is dropped.
- drop_count, output, CNT_W: number of dropped records, saturating.
- retired_count, output, 32: total retirements detected, including dropped ones; wraps.

Behaviour:
- Reset (RST=0, asynchronous), every output clears:
  - trace_valid=0, overflow=0, drop_count=0, retired_count=0.
  - All trace_* data outputs=0.
  - FIFO pointers cleared; prev_state=S_IF; tracker FSM in IDLE.
- Retirement event (retire): prev_state!=S_IF && state==S_IF, sampled each cycle. prev_state is a register of `state`.
- Tracker FSM, two states:
  - IDLE: waits for state!=S_IF. On that cycle it latches curPC and Op, clears cycle_cnt to 1 and clears the wen/wreg/wdata accumulators, then goes to ACTIVE.
  - ACTIVE: cycle_cnt increments each cycle and saturates at 4'hF. Each cycle with RegWre=1 latches WriteReg/WriteData and sets wen (last write wins).
  - On retire: push the record, return to IDLE, increment retired_count.
  - If retire and a new leave-IF happen together, IDLE semantics apply on the next cycle; IF always lasts at least 1 cycle, so they never overlap.
- Reset mid-instruction: the partial record is discarded and no push occurs.
- FIFO, registered, first-word visible:
  - A record pushed at edge N is presented with trace_valid=1 after edge N (1-cycle latency).
  - The head pops on a cycle with trace_valid && trace_ready.
- Full with retire and no pop: the record is dropped, overflow is set (sticky until reset), and drop_count increments, saturating at all-ones.
- Full with retire and a pop in the same cycle: the push is accepted and nothing is dropped.
- Empty: trace_valid=0 and the data outputs hold their last value; no contract is placed on that value.
- Occupancy counter is clog2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
- trace_ready is ignored while trace_valid=0.

Optional Feature:
- Macro: COMMIT_TRACE_CYCLES_EN.
- Defined: cycle_cnt logic is present and trace_cycles carries the saturating per-instruction cycle count (IF cycle excluded, leave-IF cycle counted as 1).
- Undefined: the counter is not built, the FIFO entry omits the 4-bit field, and trace_cycles is tied to 0.

Decomposition:
- Package commit_trace_pkg holds:
  - CPU state encoding constants: S_IF=3'b000, S_ID=3'b001, S_EXE=3'b010, S_MEM=3'b011, S_WB=3'b100.
  - The commit record struct typedef: pc, op, wreg, wdata, wen, cycles.
  - Record width constants.
- One sub-module is natural: commit_trace_fifo, a generic DEPTH-entry synchronous FIFO with full, empty and count. It is instantiated once; the tracker FSM stays in the top module.

Test Plan:
- Single instruction, with trace_ready=1 throughout:
  - Stimulus: IF→ID→EXE→WB→IF at PC=0x00000004, Op=6'h00, with RegWre=1 in WB, WriteReg=5'd3, WriteData=0x0000_0007.
  - Response: one cycle after return to IF, trace_valid=1 with pc=0x4, wreg=3, wdata=7, wen=1, cycles=3; retired_count=1.
- Store with no register write:
  - Stimulus: IF→ID→EXE→MEM→IF, RegWre never asserted.
  - Response: wen=0, cycles=3.
- Back-pressure overflow:
  - Stimulus: trace_ready=0 for 10 retirements with DEPTH=8.
  - Response: 8 records retained in order; overflow=1, drop_count=2, retired_count=10. Then trace_ready=1 drains exactly the 8 original PCs in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, and retire coincides with trace_ready=1.
  - Response: no drop (drop_count unchanged) and occupancy stays 8.
- Mid-instruction reset:
  - Stimulus: RST=0 asserted asynchronously during EXE, then released.
  - Response: all outputs return to 0 immediately and no record appears for the aborted instruction.
- Saturation:
  - Stimulus: 20 cycles spent outside IF before retiring.
  - Response: trace_cycles=4'hF with COMMIT_TRACE_CYCLES_EN defined, 0 without it.
